// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: occupancy encoding and the entry
// layout handed from EX to the register-file write port.
package wb_pkg;

  localparam int unsigned WB_XLEN   = 64;
  localparam int unsigned WB_REG_AW = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_occ_e;

  // Reference layout at the default widths; the top level re-declares the
  // same field order at its own parameter values.
  typedef struct packed {
    logic [WB_XLEN-1:0]   pc;
    logic                 we;
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_entry_t;

  localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

  function automatic int unsigned entry_width(input int unsigned xlen,
                                              input int unsigned reg_aw);
    return xlen + 1 + reg_aw + xlen;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry elastic buffer (main + skid) with a three-state occupancy FSM.
// Upstream ready is decoded from the state register and flush only.
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter int unsigned W = WB_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  wb_occ_e      state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         accept;
  logic         pop;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // NOTE: the entry registers are reset because M must read as zero after
  // reset (wb_pc_o and the RF outputs are observed directly).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign accept = in_valid_i && in_ready_o;
  assign pop    = out_valid_o && out_ready_i && !flush_i;

  // NOTE: every variable gets a hold default first so no path leaves one
  // unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      // Payload registers keep their contents; only occupancy is cleared.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = in_data_i;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_d = in_data_i;
          end else if (accept) begin
            state_d = TWO;
            s_d     = in_data_i;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q != TWO) && !flush_i;
    out_valid_o = (state_q != EMPTY);
    out_data_o  = m_q;
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Write-back stage: buffers retiring instructions from EX, drives the
// register-file write port and counts retirements.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic              ex_rd_we_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_rd_data_i,
  input  logic              commit_stall_i,
  input  logic              flush_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              wb_valid_o,
  output logic [XLEN-1:0]   wb_pc_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  localparam int unsigned ENTRY_W = entry_width(XLEN, REG_AW);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t           in_entry;
  entry_t           m_entry;
  logic [ENTRY_W-1:0] m_raw;
  logic             m_valid;
  logic             retire;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    in_entry.pc   = ex_pc_i;
    in_entry.we   = ex_rd_we_i;
    in_entry.rd   = ex_rd_i;
    in_entry.data = ex_rd_data_i;
  end

  wb_skid_buf #(
    .W (ENTRY_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (ex_valid_i),
    .in_ready_o  (ex_ready_o),
    .in_data_i   (in_entry),
    .out_valid_o (m_valid),
    .out_ready_i (!commit_stall_i),
    .out_data_o  (m_raw)
  );

  assign m_entry = entry_t'(m_raw);

  // Flush outranks retirement: a flushed head never reaches the RF.
  assign retire = m_valid && !commit_stall_i && !flush_i;

  always_comb begin
    rf_we_o    = retire && m_entry.we && (m_entry.rd != '0);
    rf_waddr_o = m_entry.rd;
    rf_wdata_o = m_entry.data;
    wb_valid_o = m_valid;
    wb_pc_o    = m_entry.pc;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe with hand-computed expectations; a 4-bit
// retire counter keeps the wrap case short.
module tb_wb_stage_pipe;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              ex_valid_i;
  logic              ex_ready_o;
  logic [XLEN-1:0]   ex_pc_i;
  logic              ex_rd_we_i;
  logic [REG_AW-1:0] ex_rd_i;
  logic [XLEN-1:0]   ex_rd_data_i;
  logic              commit_stall_i;
  logic              flush_i;
  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [XLEN-1:0]   rf_wdata_o;
  logic              wb_valid_o;
  logic [XLEN-1:0]   wb_pc_o;
  logic [CNT_W-1:0]  retire_cnt_o;

  int n_cmp = 0;
  int n_mis = 0;

  wb_stage_pipe #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_i     (ex_valid_i),
    .ex_ready_o     (ex_ready_o),
    .ex_pc_i        (ex_pc_i),
    .ex_rd_we_i     (ex_rd_we_i),
    .ex_rd_i        (ex_rd_i),
    .ex_rd_data_i   (ex_rd_data_i),
    .commit_stall_i (commit_stall_i),
    .flush_i        (flush_i),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .wb_valid_o     (wb_valid_o),
    .wb_pc_o        (wb_pc_o),
    .retire_cnt_o   (retire_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] rd,
                       input logic we, input logic [63:0] d);
    ex_valid_i   = v;
    ex_pc_i      = pc;
    ex_rd_i      = rd;
    ex_rd_we_i   = we;
    ex_rd_data_i = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_cnt;
    rst            = 1'b0;
    commit_stall_i = 1'b0;
    flush_i        = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0);
    exp_cnt = 4'd0;

    // Reset state
    #12;
    check("rst_valid", 64'(wb_valid_o), 64'd0);
    check("rst_rf_we", 64'(rf_we_o), 64'd0);
    check("rst_ready", 64'(ex_ready_o), 64'd1);
    check("rst_cnt",   64'(retire_cnt_o), 64'd0);
    check("rst_pc",    wb_pc_o, 64'd0);
    next_cycle();
    rst = 1'b1;

    // Back-to-back stream, no stall: rd 1..4 retire on consecutive cycles
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, 64'h100 + 64'(4 * c), 5'(c + 1), 1'b1, 64'hD000 + 64'(c));
      else       drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0);
      @(negedge clk);
      check("b2b_ready", 64'(ex_ready_o), 64'd1);
      if (c >= 1 && c <= 4) begin
        check("b2b_we",    64'(rf_we_o), 64'd1);
        check("b2b_waddr", 64'(rf_waddr_o), 64'(c));
        check("b2b_wdata", rf_wdata_o, 64'hD000 + 64'(c - 1));
        check("b2b_pc",    wb_pc_o, 64'h100 + 64'(4 * (c - 1)));
      end
      next_cycle();
    end
    exp_cnt = 4'd4;
    @(negedge clk);
    check("b2b_idle_we",  64'(rf_we_o), 64'd0);
    check("b2b_idle_vld", 64'(wb_valid_o), 64'd0);
    check("b2b_cnt",      64'(retire_cnt_o), 64'(exp_cnt));
    next_cycle();

    // Stall fill: A and B absorbed, C refused until release drains A
    commit_stall_i = 1'b1;
    drive(1'b1, 64'h200, 5'd5, 1'b1, 64'hA5);
    @(negedge clk);
    check("stall_rdy0", 64'(ex_ready_o), 64'd1);
    next_cycle();
    drive(1'b1, 64'h204, 5'd6, 1'b1, 64'hB6);
    @(negedge clk);
    check("stall_rdy1", 64'(ex_ready_o), 64'd1);
    check("stall_we1",  64'(rf_we_o), 64'd0);
    check("stall_vld1", 64'(wb_valid_o), 64'd1);
    next_cycle();
    drive(1'b1, 64'h208, 5'd7, 1'b1, 64'hC7);
    @(negedge clk);
    check("stall_full_rdy", 64'(ex_ready_o), 64'd0);
    check("stall_full_we",  64'(rf_we_o), 64'd0);
    check("stall_full_pc",  wb_pc_o, 64'h200);
    next_cycle();
    commit_stall_i = 1'b0;
    @(negedge clk);
    check("rel_rdy",   64'(ex_ready_o), 64'd0);
    check("rel_we_a",  64'(rf_we_o), 64'd1);
    check("rel_addr_a", 64'(rf_waddr_o), 64'd5);
    next_cycle();
    @(negedge clk);
    check("rel_rdy_b",  64'(ex_ready_o), 64'd1);
    check("rel_addr_b", 64'(rf_waddr_o), 64'd6);
    check("rel_data_b", rf_wdata_o, 64'hB6);
    next_cycle();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0);
    @(negedge clk);
    check("rel_we_c",   64'(rf_we_o), 64'd1);
    check("rel_addr_c", 64'(rf_waddr_o), 64'd7);
    next_cycle();
    exp_cnt = exp_cnt + 4'd3;
    @(negedge clk);
    check("stall_cnt", 64'(retire_cnt_o), 64'(exp_cnt));
    next_cycle();

    // x0 write retires and counts without an RF write
    drive(1'b1, 64'h300, 5'd0, 1'b1, 64'hDEAD);
    next_cycle();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0);
    @(negedge clk);
    check("x0_vld", 64'(wb_valid_o), 64'd1);
    check("x0_we",  64'(rf_we_o), 64'd0);
    check("x0_pc",  wb_pc_o, 64'h300);
    next_cycle();
    exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    check("x0_vld_end", 64'(wb_valid_o), 64'd0);
    check("x0_cnt",     64'(retire_cnt_o), 64'(exp_cnt));
    next_cycle();

    // Flush with two buffered entries
    commit_stall_i = 1'b1;
    drive(1'b1, 64'h400, 5'd9, 1'b1, 64'h99);
    next_cycle();
    drive(1'b1, 64'h404, 5'd10, 1'b1, 64'hAA);
    next_cycle();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0);
    @(negedge clk);
    check("fl_two_rdy", 64'(ex_ready_o), 64'd0);
    next_cycle();
    commit_stall_i = 1'b0;
    flush_i        = 1'b1;
    @(negedge clk);
    check("fl_we",  64'(rf_we_o), 64'd0);
    check("fl_rdy", 64'(ex_ready_o), 64'd0);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    check("fl_after_vld", 64'(wb_valid_o), 64'd0);
    check("fl_after_rdy", 64'(ex_ready_o), 64'd1);
    check("fl_after_we",  64'(rf_we_o), 64'd0);
    check("fl_after_cnt", 64'(retire_cnt_o), 64'(exp_cnt));
    check("fl_hold_pc",   wb_pc_o, 64'h400);
    next_cycle();

    // Asynchronous reset while M is retiring
    drive(1'b1, 64'h500, 5'd11, 1'b1, 64'h55);
    next_cycle();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0);
    @(negedge clk);
    check("ar_pre_we", 64'(rf_we_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_vld", 64'(wb_valid_o), 64'd0);
    check("ar_we",  64'(rf_we_o), 64'd0);
    check("ar_cnt", 64'(retire_cnt_o), 64'd0);
    check("ar_pc",  wb_pc_o, 64'd0);
    next_cycle();
    rst = 1'b1;
    exp_cnt = 4'd0;

    // Counter wrap: 17 retirements on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 64'h600 + 64'(4 * i), 5'd1, 1'b1, 64'(i));
      next_cycle();
    end
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0);
    next_cycle();
    exp_cnt = 4'd1;
    @(negedge clk);
    check("wrap_cnt", 64'(retire_cnt_o), 64'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised write-back stage for the in-order pipe, the successor to the single-register WB stage. Accepts retiring instructions from EX over a valid/ready handshake, buffers up to two entries so that `ex_ready_o` depends only on registered state, and drives the register-file write port. Adds commit stall, flush, x0 write suppression and a retire counter.

## Interface
- `XLEN`, 64: data and PC width.
- `REG_AW`, 5: register address width.
- `CNT_W`, 64: retire counter width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ex_valid_i` in 1: EX holds a valid instruction.
- `ex_ready_o` out 1: WB accepts this cycle.
- `ex_pc_i` in XLEN: instruction PC.
- `ex_rd_we_i` in 1: instruction writes `rd`.
- `ex_rd_i` in REG_AW: destination register.
- `ex_rd_data_i` in XLEN: write-back data.
- `commit_stall_i` in 1: hold retirement (debug halt, trap sequencing).
- `flush_i` in 1: discard all buffered entries.
- `rf_we_o` out 1: register-file write enable.
- `rf_waddr_o` out REG_AW: register-file write address.
- `rf_wdata_o` out XLEN: register-file write data.
- `wb_valid_o` out 1: main entry is occupied.
- `wb_pc_o` out XLEN: PC of the main entry.
- `retire_cnt_o` out CNT_W: count of retired instructions.

## Operation
- Storage:
  - Main entry M is the head and is the retire candidate.
  - Skid entry S holds the second entry.
  - Occupancy FSM states are EMPTY, ONE (M valid) and TWO (M and S valid).
- `ex_ready_o` = (state != TWO) && !flush_i. It is decoded from the state register plus `flush_i` only, never from `ex_valid_i` or `commit_stall_i`.
- Accept = `ex_valid_i && ex_ready_o`.
- Retire = M valid && !commit_stall_i && !flush_i.
- `rf_we_o` = retire && M.we && (M.rd != 0).
  - `rf_waddr_o` and `rf_wdata_o` come from M.
  - A write to x0 retires and counts, but `rf_we_o` stays 0.
- FSM transitions:
  - EMPTY: accept → ONE, payload into M.
  - ONE:
    - accept and retire → ONE, new payload into M.
    - accept only → TWO, payload into S.
    - retire only → EMPTY.
    - neither → hold.
  - TWO: no accept is possible. Retire → ONE, with S moving to M.
- Flush:
  - `flush_i` forces state EMPTY at the next edge.
  - In the flush cycle there is no retire, no RF write, no accept and no counter increment.
  - Flush has priority over every other event.
- `retire_cnt_o` increments by 1 on each retire and wraps modulo 2^CNT_W with no saturation.
- `wb_pc_o` and the RF data/address outputs hold M's last contents when EMPTY. Only `wb_valid_o` and `rf_we_o` qualify them.
- Entry payload is {pc, we, rd, data}, i.e. XLEN+1+REG_AW+XLEN bits.

## Timing
- Reset values, applied asynchronously while `rst`=0:
  - state EMPTY.
  - M, S and `retire_cnt_o` = 0.
  - `wb_valid_o`=0, `rf_we_o`=0, `wb_pc_o`=0.
  - `ex_ready_o`=1, since the state is EMPTY.
- Reset asserted mid-operation drops both entries immediately. No RF write is issued after assertion.
- Latency:
  - An instruction accepted at edge N is in M during cycle N+1.
  - With no stall, `rf_we_o` is high in cycle N+1 and the RF samples at edge N+2.
- Throughput is 1 per cycle while `commit_stall_i`=0.
- Under stall the stage absorbs exactly 2 instructions, then `ex_ready_o` falls in the cycle after the second accept.
- After stall release with TWO:
  - M retires in the release cycle.
  - `ex_ready_o` returns to 1 in the following cycle.
  - S retires one cycle after M.
- Upstream holds `ex_valid_i` and its payload until accepted. WB never drops an accepted entry except on flush or reset.

## Structure
- Package `wb_pkg`:
  - `wb_occ_e` enum {EMPTY, ONE, TWO}.
  - `wb_entry_t` packed struct {pc, we, rd, data}, parametrised via XLEN/REG_AW defaults.
- One sub-module, `wb_skid_buf`: the 2-entry buffer plus occupancy FSM, generic in payload width, exposing in/out valid/ready and a flush input.
- Top level holds the retire and RF-write decode and the retire counter.

## Test plan
- Back-to-back stream: 4 instructions, no stall, pc 0x100..0x10C, rd=1..4 → `rf_we_o` high 4 consecutive cycles, addresses 1..4 in order, `retire_cnt_o`=4, `ex_ready_o` constantly 1.
- Stall fill: `commit_stall_i`=1, offer 3 instructions → first two accepted, `ex_ready_o`=0 from the cycle after the second accept. Release → retires in order, third accepted once ready=1, count=3.
- x0 write: rd=0, we=1, data=0xDEAD → `rf_we_o`=0, `wb_valid_o` pulse, `retire_cnt_o` +1.
- Flush in TWO: with 2 buffered entries, pulse `flush_i` → no RF write, count unchanged, state EMPTY, `ex_ready_o`=1 the next cycle.
- Async reset mid-stream: deassert `rst` between edges with M valid → `wb_valid_o`, `rf_we_o` and the counter go to 0 without a clock edge.
- Counter wrap: CNT_W=4, retire 17 instructions → `retire_cnt_o`=1.
